// File: rtl/run_scheduler.sv
// run_scheduler: round-robin launcher for the shared program core.
// Picks a pending requester, pulses core_start with its address, watches
// for core_done under a watchdog and reports completion to the owner.
module run_scheduler #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_address,
  output logic [N_REQ-1:0]          grant,
  output logic                      core_start,
  output logic [ADDR_W-1:0]         core_start_address,
  input  logic                      core_done,
  output logic [N_REQ-1:0]          job_done,
  output logic                      job_timeout,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic [CNT_W-1:0]          cycle_count
);

  localparam int unsigned OWN_W = $clog2(N_REQ);
  localparam int unsigned SUM_W = OWN_W + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 core_start_q, core_start_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [N_REQ-1:0]     job_done_q, job_done_d;
  logic                 job_timeout_q, job_timeout_d;
  logic                 busy_q, busy_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic                 tmo_flag_q, tmo_flag_d;

  logic [N_REQ-1:0]     rot;
  logic                 pick_valid;
  logic [OWN_W-1:0]     pick_off;
  logic [SUM_W-1:0]     win_sum;
  logic [OWN_W-1:0]     win;
  logic [ADDR_W-1:0]    win_addr;
  logic [CNT_W-1:0]     cnt_inc;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take first set bit
  always_comb begin
    rot        = N_REQ'({req, req} >> rr_ptr_q);
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (rot[i] && !pick_valid) begin
        pick_valid = 1'b1;
        pick_off   = OWN_W'(i);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (win_sum >= SUM_W'(N_REQ)) begin
      win_sum = win_sum - SUM_W'(N_REQ);
    end
    win = win_sum[OWN_W-1:0];
    win_addr = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win == OWN_W'(i)) begin
        win_addr = req_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d       = state_q;
    grant_d       = '0;
    core_start_d  = 1'b0;
    addr_d        = addr_q;
    job_done_d    = '0;
    job_timeout_d = 1'b0;
    owner_d       = owner_q;
    cycle_count_d = cycle_count_q;
    rr_ptr_d      = rr_ptr_q;
    counter_d     = counter_q;
    tmo_flag_d    = tmo_flag_q;
    cnt_inc       = counter_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d   = N_REQ'(1) << win;
          owner_d   = win;
          addr_d    = win_addr;
          counter_d = '0;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        core_start_d = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (counter_q != CNT_W'(TIMEOUT)) begin
          counter_d = cnt_inc;
        end
        if (core_done) begin
          cycle_count_d = cnt_inc;
          state_d       = FINISH;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          cycle_count_d = CNT_W'(TIMEOUT);
          tmo_flag_d    = 1'b1;
          state_d       = FINISH;
        end
      end
      FINISH: begin
        job_done_d    = N_REQ'(1) << owner_q;
        job_timeout_d = tmo_flag_q;
        tmo_flag_d    = 1'b0;
        rr_ptr_d      = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      core_start_q  <= 1'b0;
      addr_q        <= '0;
      job_done_q    <= '0;
      job_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      owner_q       <= '0;
      cycle_count_q <= '0;
      rr_ptr_q      <= '0;
      counter_q     <= '0;
      tmo_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      core_start_q  <= core_start_d;
      addr_q        <= addr_d;
      job_done_q    <= job_done_d;
      job_timeout_q <= job_timeout_d;
      busy_q        <= busy_d;
      owner_q       <= owner_d;
      cycle_count_q <= cycle_count_d;
      rr_ptr_q      <= rr_ptr_d;
      counter_q     <= counter_d;
      tmo_flag_q    <= tmo_flag_d;
    end
  end

  assign grant              = grant_q;
  assign core_start         = core_start_q;
  assign core_start_address = addr_q;
  assign job_done           = job_done_q;
  assign job_timeout        = job_timeout_q;
  assign busy               = busy_q;
  assign owner              = owner_q;
  assign cycle_count        = cycle_count_q;

endmodule

// File: tb/tb_run_scheduler.sv
// Directed bench for run_scheduler with a short watchdog (TIMEOUT=16).
module tb_run_scheduler;

  localparam int unsigned N_REQ   = 3;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*ADDR_W-1:0]  req_address;
  logic [N_REQ-1:0]         grant;
  logic                     core_start;
  logic [ADDR_W-1:0]        core_start_address;
  logic                     core_done;
  logic [N_REQ-1:0]         job_done;
  logic                     job_timeout;
  logic                     busy;
  logic [1:0]               owner;
  logic [CNT_W-1:0]         cycle_count;

  int total = 0;
  int bad   = 0;

  run_scheduler #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req                (req),
    .req_address        (req_address),
    .grant              (grant),
    .core_start         (core_start),
    .core_start_address (core_start_address),
    .core_done          (core_done),
    .job_done           (job_done),
    .job_timeout        (job_timeout),
    .busy               (busy),
    .owner              (owner),
    .cycle_count        (cycle_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".grant"},   32'(grant), 0);
    chk({tag, ".start"},   32'(core_start), 0);
    chk({tag, ".addr"},    32'(core_start_address), 0);
    chk({tag, ".jdone"},   32'(job_done), 0);
    chk({tag, ".jtmo"},    32'(job_timeout), 0);
    chk({tag, ".busy"},    32'(busy), 0);
    chk({tag, ".owner"},   32'(owner), 0);
    chk({tag, ".ccount"},  32'(cycle_count), 0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    core_done = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // One job from the picking edge to the first IDLE cycle after job_done.
  // done_at: RUN cycle (1-based) in which core_done is high, 0 = never.
  task automatic run_job(input string tag, input logic [2:0] g, input logic [6:0] a,
                         input int own, input int done_at, input int cc, input logic to);
    step();
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".addr"},  32'(core_start_address), 32'(a));
    chk({tag, ".owner"}, 32'(owner), 32'(own));
    chk({tag, ".busy"},  32'(busy), 1);
    chk({tag, ".start_early"}, 32'(core_start), 0);
    req = req & ~g;
    step();
    chk({tag, ".start"}, 32'(core_start), 1);
    chk({tag, ".grant_off"}, 32'(grant), 0);
    for (int c = 1; c <= cc; c++) begin
      core_done = (c == done_at);
      chk({tag, ".run_jdone"}, 32'(job_done), 0);
      chk({tag, ".run_busy"},  32'(busy), 1);
      step();
    end
    core_done = 1'b0;
    chk({tag, ".fin_jdone"}, 32'(job_done), 0);
    chk({tag, ".fin_busy"},  32'(busy), 1);
    step();
    chk({tag, ".jdone"},  32'(job_done), 32'(g));
    chk({tag, ".jtmo"},   32'(job_timeout), 32'(to));
    chk({tag, ".ccount"}, 32'(cycle_count), 32'(cc));
    chk({tag, ".busy_off"}, 32'(busy), 0);
    chk({tag, ".idle_grant"}, 32'(grant), 0);
    chk({tag, ".addr_hold"}, 32'(core_start_address), 32'(a));
  endtask

  initial begin
    reset_n     = 1'b0;
    req         = '0;
    core_done   = 1'b0;
    req_address = {7'h7F, 7'h20, 7'h11};

    // reset values
    do_reset();
    chk_reset_vals("reset");

    // single job: requester 1, done in the 5th RUN cycle
    req = 3'b010;
    run_job("single", 3'b010, 7'h20, 1, 5, 5, 1'b0);

    // round robin from a fresh pointer, all held, 2-cycle jobs (gap 5)
    do_reset();
    req = 3'b111;
    run_job("rr0", 3'b001, 7'h11, 0, 2, 2, 1'b0);
    req = 3'b111;
    run_job("rr1", 3'b010, 7'h20, 1, 2, 2, 1'b0);
    req = 3'b111;
    run_job("rr2", 3'b100, 7'h7F, 2, 2, 2, 1'b0);
    req = 3'b111;
    run_job("rr3", 3'b001, 7'h11, 0, 2, 2, 1'b0);
    req = 3'b000;
    step();
    chk("rr_idle.grant", 32'(grant), 0);

    // timeout: done never arrives
    req = 3'b100;
    run_job("tmo", 3'b100, 7'h7F, 2, 0, 16, 1'b1);

    // normal job after a timeout
    req = 3'b001;
    run_job("after_tmo", 3'b001, 7'h11, 0, 3, 3, 1'b0);

    // done on the timeout boundary: done wins
    req = 3'b010;
    run_job("collide", 3'b010, 7'h20, 1, 16, 16, 1'b0);

    // stale done held through IDLE and LAUNCH
    core_done = 1'b1;
    req = 3'b001;
    run_job("stale", 3'b001, 7'h11, 0, 4, 4, 1'b0);

    // reset in the middle of RUN
    req = 3'b010;
    step();
    chk("mid.grant", 32'(grant), 32'(3'b010));
    req = 3'b000;
    step();
    chk("mid.start", 32'(core_start), 1);
    step();
    step();
    chk("mid.busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    step();
    chk("mid_rst.jdone_held", 32'(job_done), 0);
    reset_n = 1'b1;
    req = 3'b011;
    run_job("post_rst", 3'b001, 7'h11, 0, 2, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_scheduler.md
# run_scheduler

Sequences the shared program core (start / start_address / done) for several requesters. It arbitrates round-robin among pending run requests and issues a one-cycle start pulse with the winner's start address. It then waits for the core's done, enforcing a watchdog timeout, and reports completion, timeout and measured run length back to the owner. It sits between the per-program launch logic and the core's start/done handshake.

## Interface
- N_REQ, 3: number of requesters (2..8)
- ADDR_W, 7: width of a program start address
- CNT_W, 16: width of the run-length counter and cycle_count
- TIMEOUT, 4096: RUN cycles without done before the job is aborted (1 .. 2^CNT_W-1)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  level request per requester; held until its grant pulse
- req_address  in  N_REQ*ADDR_W  start address of requester i at bits [i*ADDR_W +: ADDR_W]
- grant  out  N_REQ  one-hot, one-cycle pulse when requester's job is accepted
- core_start  out  1  one-cycle start pulse to the core
- core_start_address  out  ADDR_W  address of the current job; stable from grant until next grant
- core_done  in  1  core completion (level or pulse)
- job_done  out  N_REQ  one-hot, one-cycle pulse to the owner when its job ends (normal or timeout)
- job_timeout  out  1  one-cycle pulse coincident with job_done when the job timed out
- busy  out  1  high in LAUNCH, RUN, FINISH
- owner  out  $clog2(N_REQ)  index of the current/last job owner
- cycle_count  out  CNT_W  run length of the last finished job

## Operation
- FSM states: IDLE, LAUNCH, RUN, FINISH. All outputs are registered.
- **IDLE:**
  - If any req bit is set, the arbiter picks the first set bit searching upward (with wrap) from rr_ptr.
  - On the picking edge: grant[winner] pulses, owner=winner, core_start_address=req_address[winner], counter cleared, go LAUNCH.
  - If no req bit is set, stay in IDLE.
- **LAUNCH:** core_start=1 for exactly this cycle; core_done is ignored. Next state is RUN.
- **RUN:** counter increments every cycle, saturating at TIMEOUT.
  - core_done sampled high: cycle_count = counter+1, go FINISH.
  - Else if counter+1 == TIMEOUT: cycle_count = TIMEOUT, timeout flag set, go FINISH.
  - core_done and the timeout boundary in the same cycle: done wins, no timeout.
- **FINISH:** job_done[owner]=1, job_timeout = flag, flag cleared, rr_ptr = (owner+1) mod N_REQ, go IDLE.
- **Requests:**
  - A req deasserted before its grant is simply never granted.
  - req bits of the current owner are ignored while busy.
  - A requester may re-request the cycle after its job_done. It then loses to any other pending requester.
- **Reset (any time, including mid-RUN):**
  - State IDLE; grant, core_start, job_done, job_timeout, busy = 0; owner=0; core_start_address=0; cycle_count=0; rr_ptr=0; counter=0.
  - An interrupted job gets no job_done.

## Timing
- grant edge → core_start is high in the next cycle (1-cycle latency).
- The core must see core_start_address valid no later than core_start; it is valid from the grant cycle onward.
- Fastest job (done in the first RUN cycle): grant at T, core_start at T+1, RUN at T+2, job_done at T+3, cycle_count=1. The next grant is possible at T+4.
- Back-to-back jobs are spaced by cycle_count+3 cycles from grant to grant.
- A core_done held high from the previous job is masked in IDLE and LAUNCH. The core must drop done by the first RUN cycle, otherwise the run measures 1.
- busy rises on the grant edge and falls on the edge leaving FINISH.

## Test plan
- **Single job:** reset, req=3'b010, req_address[1]=7'h20, core_done asserted 5 cycles after core_start.
  - Expect grant=3'b010, core_start one cycle later with core_start_address=7'h20.
  - Expect job_done=3'b010, job_timeout=0, cycle_count=5, owner=1.
- **Round robin:** req=3'b111 held and re-asserted after each job_done, every job done in 2 cycles. Expect grant order 0,1,2,0 and each grant-to-grant gap of 5 cycles.
- **Timeout:** TIMEOUT=16, req[2] set, core_done never asserted.
  - Expect job_done=3'b100 with job_timeout=1 exactly 16 RUN cycles after the RUN entry, cycle_count=16.
  - The next request is then serviced normally.
- **Done/timeout collision:** TIMEOUT=16, core_done asserted in RUN cycle 16. Expect job_timeout=0, cycle_count=16.
- **Stale done:** core_done held high through IDLE and LAUNCH, dropped in the first RUN cycle, reasserted 3 cycles later. Expect no early completion and cycle_count=4.
- **Reset mid-run:** pulse reset_n low during RUN. Expect all outputs at reset values immediately, no job_done, and a fresh req[0] granted first afterwards.
